erx_deframer: RTL and testbench

Byte-rate receive deframer for the eLink RX path. Consumes the deserialized byte stream and per-byte frame flag from the RX IO stage, tracks transaction boundaries with a byte-counting state machine, and assembles 104-bit packets. Produces `rx_packet`, `rx_access`, `rx_burst` and `rx_burst_incr_addr` for the RX protocol stage directly downstream, which does burst address generation and the output pipeline.

---
 rtl/erx_deframer.sv | 180 ++++++++++++++++++
 tb/tb_erx_deframer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/erx_deframer.sv
// Deframes the eLink RX byte stream (B0 tran, B1 ctrl, 3x 32-bit words) into 104-bit packets; bursts repeat data/src.
// Latency: rx_access rises one cycle after the last byte of a beat (B13, then every 8 bytes during a burst).
// Backpressure: none, downstream takes every pulse. Optional saturating stats counters under ERX_DEFRAMER_STATS_EN.
module erx_deframer #(
    localparam int AW = 32,
    localparam int PW = 104
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_frame,
    input  logic [7:0]    rx_byte,
    output logic          rx_access,
    output logic [PW-1:0] rx_packet,
    output logic          rx_burst,
    output logic          rx_burst_incr_addr,
    output logic          rx_abort,
    output logic [15:0]   rx_pkt_count,
    output logic [15:0]   rx_abort_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CTRL,
        S_ADDR,
        S_DATA,
        S_SRC,
        S_BDATA,
        S_BSRC
    } state_t;

    state_t        state_q, state_nxt;
    logic [1:0]    cnt_q, cnt_nxt;
    logic          frame_q;
    logic [23:0]   shift_q;
    logic [7:0]    ctrl_q;
    logic [AW-1:0] dst_q;
    logic [AW-1:0] data_q;
    logic [AW-1:0] word;
    logic          frame_start;
    logic          field_done;
    logic          emit;
    logic          emit_burst;
    logic          abort_nxt;

    // frame_q resets high so a frame already in flight at reset release is not taken as a start
    assign frame_start = rx_frame & ~frame_q;
    assign field_done  = (cnt_q == 2'd3);
    // complete 32-bit field on the cycle its last byte arrives
    assign word        = {shift_q, rx_byte};

    // State, byte counter and previous-frame register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            frame_q <= 1'b1;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            frame_q <= rx_frame;
        end
    end

    // Next-state, beat-completion and abort decode
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = 2'd0;
        emit       = 1'b0;
        emit_burst = 1'b0;
        abort_nxt  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) state_nxt = S_CTRL;
            end
            S_CTRL: begin
                if (rx_frame) begin
                    state_nxt = S_ADDR;
                end else begin
                    abort_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_BDATA: begin
                // a drop before the first data byte of a new beat is the normal end of a frame
                if (!rx_frame) begin
                    abort_nxt = (cnt_q != 2'd0);
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt_q + 2'd1;
                    if (field_done) state_nxt = S_BSRC;
                end
            end
            S_ADDR, S_DATA, S_SRC, S_BSRC: begin
                if (!rx_frame) begin
                    abort_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt_q + 2'd1;
                    if (field_done) begin
                        case (state_q)
                            S_ADDR:  state_nxt = S_DATA;
                            S_DATA:  state_nxt = S_SRC;
                            S_SRC: begin
                                state_nxt = S_BDATA;
                                emit      = 1'b1;
                            end
                            default: begin
                                state_nxt  = S_BDATA;
                                emit       = 1'b1;
                                emit_burst = 1'b1;
                            end
                        endcase
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte shift register and per-field capture registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= 24'd0;
            ctrl_q  <= 8'd0;
            dst_q   <= '0;
            data_q  <= '0;
        end else begin
            shift_q <= word[23:0];
            if (state_q == S_CTRL && rx_frame) ctrl_q <= rx_byte;
            if (rx_frame && field_done && state_q == S_ADDR) dst_q <= word;
            if (rx_frame && field_done && (state_q == S_DATA || state_q == S_BDATA)) data_q <= word;
        end
    end

    // Packet holding register and output pulses; the packet only changes at beat completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_access          <= 1'b0;
            rx_burst           <= 1'b0;
            rx_abort           <= 1'b0;
            rx_burst_incr_addr <= 1'b0;
            rx_packet          <= '0;
        end else begin
            rx_access <= emit;
            rx_burst  <= emit_burst;
            rx_abort  <= abort_nxt;
            if (emit) begin
                rx_burst_incr_addr <= ctrl_q[0];
                // burst beats keep dstaddr and ctrl; downstream regenerates the address
                if (emit_burst)
                    rx_packet <= {word, data_q, rx_packet[39:0]};
                else
                    rx_packet <= {word, data_q, dst_q, ctrl_q[7:4], ctrl_q[2:1], ctrl_q[3], 1'b1};
            end
        end
    end

`ifdef ERX_DEFRAMER_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] abort_cnt_q;

    // Saturating access and abort counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt_q   <= 16'h0000;
            abort_cnt_q <= 16'h0000;
        end else begin
            if (emit && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (abort_nxt && abort_cnt_q != 16'hFFFF) abort_cnt_q <= abort_cnt_q + 16'd1;
        end
    end

    assign rx_pkt_count   = pkt_cnt_q;
    assign rx_abort_count = abort_cnt_q;
`else
    assign rx_pkt_count   = 16'h0000;
    assign rx_abort_count = 16'h0000;
`endif

endmodule

// File: tb/tb_erx_deframer.sv
// Bench for erx_deframer: directed frames, expected events queued at issue time.
// A negedge monitor pops and compares every rx_access / rx_abort, including its cycle.
// Ends with one summary line.
module tb_erx_deframer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx_frame = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         rx_access;
    logic [103:0] rx_packet;
    logic         rx_burst;
    logic         rx_burst_incr_addr;
    logic         rx_abort;
    logic [15:0]  rx_pkt_count;
    logic [15:0]  rx_abort_count;

    erx_deframer dut (
        .clk                (clk),
        .reset              (reset),
        .rx_frame           (rx_frame),
        .rx_byte            (rx_byte),
        .rx_access          (rx_access),
        .rx_packet          (rx_packet),
        .rx_burst           (rx_burst),
        .rx_burst_incr_addr (rx_burst_incr_addr),
        .rx_abort           (rx_abort),
        .rx_pkt_count       (rx_pkt_count),
        .rx_abort_count     (rx_abort_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic         is_abort;
        logic [103:0] pkt;
        logic         burst;
        logic         incr;
        logic [31:0]  cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [103:0] act, input logic [103:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic f, input logic [7:0] b);
        @(negedge clk);
        rx_frame = f;
        rx_byte  = b;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) drive(1'b1, w[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic expect_access(input logic [103:0] p, input logic bu, input logic inc);
        exp_t e;
        e.is_abort = 1'b0;
        e.pkt      = p;
        e.burst    = bu;
        e.incr     = inc;
        e.cyc      = 32'(cyc + 1);
        sb.push_back(e);
    endtask

    task automatic expect_abort();
        exp_t e;
        e.is_abort = 1'b1;
        e.pkt      = '0;
        e.burst    = 1'b0;
        e.incr     = 1'b0;
        e.cyc      = 32'(cyc + 1);
        sb.push_back(e);
    endtask

    // tran byte, ctrl, dst, data, src; the expectation is queued as the last byte goes out
    task automatic send_single(input logic [7:0] ctrl, input logic [31:0] dst, input logic [31:0] data,
                               input logic [31:0] src, input logic [103:0] pkt, input logic inc);
        drive(1'b1, 8'h00);
        drive(1'b1, ctrl);
        send_word(dst);
        send_word(data);
        send_word(src);
        expect_access(pkt, 1'b0, inc);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_access"}, 104'(rx_access), 104'd0);
        check({tag, "_burst"},  104'(rx_burst), 104'd0);
        check({tag, "_incr"},   104'(rx_burst_incr_addr), 104'd0);
        check({tag, "_abort"},  104'(rx_abort), 104'd0);
        check({tag, "_packet"}, rx_packet, 104'd0);
        check({tag, "_pktcnt"}, 104'(rx_pkt_count), 104'd0);
        check({tag, "_abtcnt"}, 104'(rx_abort_count), 104'd0);
    endtask

    // Monitor: every output event must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && (rx_access || rx_abort)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {102'd0, rx_access, rx_abort}, 104'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ev_abort",  104'(rx_abort), 104'(e.is_abort));
                check("ev_access", 104'(rx_access), 104'(!e.is_abort));
                check("ev_cycle",  104'(cyc), 104'(e.cyc));
                if (!e.is_abort) begin
                    check("ev_packet", rx_packet, e.pkt);
                    check("ev_burst",  104'(rx_burst), 104'(e.burst));
                    check("ev_incr",   104'(rx_burst_incr_addr), 104'(e.incr));
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        idle(2);

        // single write
        send_single(8'h08, 32'h80000000, 32'hDEADBEEF, 32'h81000000,
                    {32'h81000000, 32'hDEADBEEF, 32'h80000000, 8'h03}, 1'b0);
        idle(3);

        // burst with incr: three beats 8 cycles apart, [39:0] constant
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h0F);
        send_word(32'h80000000);
        send_word(32'hDEADBEEF);
        send_word(32'h81000000);
        expect_access({32'h81000000, 32'hDEADBEEF, 32'h80000000, 8'h0F}, 1'b0, 1'b1);
        send_word(32'h11111111);
        send_word(32'h22222222);
        expect_access({32'h22222222, 32'h11111111, 32'h80000000, 8'h0F}, 1'b1, 1'b1);
        send_word(32'h33333333);
        send_word(32'h44444444);
        expect_access({32'h44444444, 32'h33333333, 32'h80000000, 8'h0F}, 1'b1, 1'b1);
        idle(3);

        // abort after B7, then a normal frame right after the single low cycle
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h08);
        send_word(32'h80000000);
        drive(1'b1, 8'hDE);
        drive(1'b1, 8'hAD);
        drive(1'b0, 8'h00);
        expect_abort();
        send_single(8'h25, 32'h12345678, 32'hCAFEF00D, 32'h9ABCDEF0,
                    {32'h9ABCDEF0, 32'hCAFEF00D, 32'h12345678, 8'h29}, 1'b1);
        idle(3);

        // burst abort after 3 bytes of beat 1, from a fresh reset so counts start at 0
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h0F);
        send_word(32'hA0000004);
        send_word(32'h01020304);
        send_word(32'hB0000008);
        expect_access({32'hB0000008, 32'h01020304, 32'hA0000004, 8'h0F}, 1'b0, 1'b1);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h66);
        drive(1'b1, 8'h77);
        drive(1'b0, 8'h00);
        expect_abort();
        idle(3);
`ifdef ERX_DEFRAMER_STATS_EN
        check("pkt_count", 104'(rx_pkt_count), 104'd1);
        check("abort_count", 104'(rx_abort_count), 104'd1);
`else
        check("pkt_count", 104'(rx_pkt_count), 104'd0);
        check("abort_count", 104'(rx_abort_count), 104'd0);
`endif

        // reset mid-ADDR with rx_frame held high through and after release
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h08);
        drive(1'b1, 8'h80);
        drive(1'b1, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) drive(1'b1, 8'(i * 7 + 1));
        idle(1);
        send_single(8'h08, 32'h80000000, 32'hDEADBEEF, 32'h81000000,
                    {32'h81000000, 32'hDEADBEEF, 32'h80000000, 8'h03}, 1'b0);
        idle(2);

        // back-to-back frames separated by one low cycle
        send_single(8'h18, 32'h00000010, 32'h0BADF00D, 32'h00000020,
                    {32'h00000020, 32'h0BADF00D, 32'h00000010, 8'h13}, 1'b0);
        drive(1'b0, 8'h00);
        send_single(8'h04, 32'hFFFF0000, 32'h12121212, 32'h0000FFFF,
                    {32'h0000FFFF, 32'h12121212, 32'hFFFF0000, 8'h09}, 1'b0);
        idle(4);

        check("scoreboard_drained", 104'(sb.size()), 104'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
